// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the AES key schedule.
package aes_pkg;

  typedef enum logic [1:0] {
    KL_128  = 2'b00,
    KL_192  = 2'b01,
    KL_256  = 2'b10,
    KL_RSVD = 2'b11
  } key_len_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_SUBW,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam logic [7:0] RCON_INIT = 8'h01;

  function automatic logic [3:0] nk_of(input key_len_e kl);
    case (kl)
      KL_192:  return 4'd6;
      KL_256:  return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input key_len_e kl);
    case (kl)
      KL_192:  return 4'd12;
      KL_256:  return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Four combinational AES S-boxes: inverse as a^254 in GF(2^8), then the affine map.
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    // square-and-multiply builds a^127; one more square gives a^254 (0 maps to 0)
    for (int k = 0; k < 6; k++) begin
      r = gf_mul(r, r);
      r = gf_mul(r, a);
    end
    r = gf_mul(r, r);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign word_o[8*g +: 8] = sbox(word_i[8*g +: 8]);
  end

endmodule

// File: rtl/aes_key_sched.sv
// AES-128/192/256 key expansion, one word per cycle, round keys out on valid/ready.
module aes_key_sched
  import aes_pkg::*;
#(
  parameter int SBOX_REG = 0
) (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         clear_i,
  input  logic [1:0]   key_len_i,
  input  logic [255:0] key_i,
  input  logic         rk_ready_i,
  output logic         rk_valid_o,
  output logic [127:0] rk_o,
  output logic [3:0]   rk_idx_o,
  output logic         busy_o,
  output logic         done_o
);

  state_e           state;
  logic [3:0]       nk, nr, ridx;
  logic [5:0]       widx, ntot;
  logic [2:0]       kpos;
  logic [7:0]       rcon;
  logic [7:0][31:0] key_q, hist;
  logic [3:0][31:0] asm_q;
  logic             asm_full;
  logic [31:0]      sub_q, sub_in, sub_out, sub_val, temp, w_new;
  logic             need_sub, last_word, stall, gen, load_rk;

  assign ntot      = {nr, 2'b00} + 6'd4;
  assign last_word = (widx == ntot - 6'd1);
  assign need_sub  = (widx >= {2'b00, nk}) && ((kpos == 3'd0) || (nk == 4'd8 && kpos == 3'd4));
  assign sub_in    = (kpos == 3'd0) ? {hist[0][23:0], hist[0][31:24]} : hist[0];

  aes_sbox_word u_sbox (.word_i(sub_in), .word_o(sub_out));

  assign sub_val = (SBOX_REG != 0) ? sub_q : sub_out;

  always_comb begin
    temp = hist[0];
    if (need_sub) begin
      temp = sub_val;
      if (kpos == 3'd0) temp = temp ^ {rcon, 24'h0};
    end
  end

  // hist[0] is w[i-1], so w[i-Nk] sits at hist[Nk-1]
  assign w_new = (widx < {2'b00, nk}) ? key_q[7] : (hist[3'(nk - 4'd1)] ^ temp);

  // hold back only the word that would finish a key while the output slot is still occupied
  assign stall   = rk_valid_o && !rk_ready_i && (widx[1:0] == 2'b11);
  assign gen     = !stall && ((state == ST_EXPAND && !(SBOX_REG != 0 && need_sub)) || state == ST_SUBW);
  assign load_rk = asm_full && (!rk_valid_o || rk_ready_i);

  assign busy_o = (state != ST_IDLE);
  assign done_o = (state == ST_DONE);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      nk         <= '0;
      nr         <= '0;
      ridx       <= '0;
      widx       <= '0;
      kpos       <= '0;
      rcon       <= RCON_INIT;
      key_q      <= '0;
      hist       <= '0;
      asm_q      <= '0;
      asm_full   <= 1'b0;
      sub_q      <= '0;
      rk_valid_o <= 1'b0;
      rk_o       <= '0;
      rk_idx_o   <= '0;
    end else if (clear_i) begin
      state      <= ST_IDLE;
      ridx       <= '0;
      widx       <= '0;
      kpos       <= '0;
      rcon       <= RCON_INIT;
      asm_full   <= 1'b0;
      rk_valid_o <= 1'b0;
    end else begin
      if (load_rk) begin
        rk_o       <= asm_q;
        rk_idx_o   <= ridx;
        ridx       <= ridx + 4'd1;
        rk_valid_o <= 1'b1;
        asm_full   <= 1'b0;
      end else if (rk_valid_o && rk_ready_i) begin
        rk_valid_o <= 1'b0;
      end

      if (state == ST_EXPAND) sub_q <= sub_out;

      if (gen) begin
        hist                     <= {hist[6:0], w_new};
        key_q                    <= {key_q[6:0], 32'h0};
        asm_q[2'd3 - widx[1:0]]  <= w_new;
        if (widx[1:0] == 2'b11) asm_full <= 1'b1;
        widx <= widx + 6'd1;
        kpos <= ({1'b0, kpos} == nk - 4'd1) ? 3'd0 : kpos + 3'd1;
        if (need_sub && kpos == 3'd0) rcon <= xtime(rcon);
      end

      case (state)
        ST_IDLE: if (start_i) begin
          nk       <= nk_of(key_len_e'(key_len_i));
          nr       <= nr_of(key_len_e'(key_len_i));
          key_q    <= key_i;
          ridx     <= '0;
          widx     <= '0;
          kpos     <= '0;
          rcon     <= RCON_INIT;
          asm_full <= 1'b0;
          state    <= ST_EXPAND;
        end
        ST_EXPAND: begin
          if (SBOX_REG != 0 && need_sub) state <= ST_SUBW;
          else if (gen && last_word)     state <= ST_DRAIN;
        end
        ST_SUBW: if (gen) state <= last_word ? ST_DRAIN : ST_EXPAND;
        ST_DRAIN: if (rk_valid_o && rk_ready_i && !asm_full && rk_idx_o == nr) state <= ST_DONE;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_sched.sv
// Runs SBOX_REG=0 and SBOX_REG=1 instances side by side against a FIPS-197 style expansion model.
module tb_aes_key_sched;

  logic         clk_i = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic         clear_i = 1'b0;
  logic         rk_ready_i = 1'b1;
  logic [1:0]   key_len_i = '0;
  logic [255:0] key_i = '0;

  logic [1:0]        v, done, busy;
  logic [1:0][127:0] rk;
  logic [1:0][3:0]   idx;

  int tests = 0, fails = 0, cyc = 0;
  int unsigned low_pct = 0;
  bit timing_chk = 1'b0;
  int start_edge = 0;

  logic [7:0]   sb [256];
  logic [31:0]  exp_w [60];
  logic [127:0] exp_rk [15];
  int           exp_n = 0;

  int           hs_cnt [2];
  int           done_cnt [2];
  int           last_hs [2];
  bit           hold [2];
  logic [127:0] hold_rk [2];
  logic [3:0]   hold_idx [2];

  localparam logic [255:0] KEY_A = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY_B = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY_C = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_sched #(.SBOX_REG(0)) dut0 (
    .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i), .clear_i(clear_i),
    .key_len_i(key_len_i), .key_i(key_i), .rk_ready_i(rk_ready_i),
    .rk_valid_o(v[0]), .rk_o(rk[0]), .rk_idx_o(idx[0]), .busy_o(busy[0]), .done_o(done[0])
  );

  aes_key_sched #(.SBOX_REG(1)) dut1 (
    .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i), .clear_i(clear_i),
    .key_len_i(key_len_i), .key_i(key_i), .rk_ready_i(rk_ready_i),
    .rk_valid_o(v[1]), .rk_o(rk[1]), .rk_idx_o(idx[1]), .busy_o(busy[1]), .done_o(done[1])
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, expv);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      logic [7:0] c;
      inv = 8'h00;
      c = 8'h63;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic model(input logic [255:0] k, input logic [1:0] kl);
    int nk, nr;
    logic [7:0]  rc;
    logic [31:0] t;
    nk = (kl == 2'b01) ? 6 : (kl == 2'b10) ? 8 : 4;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 4*(nr+1); i++) begin
      if (i < nk) exp_w[i] = k[255-32*i -: 32];
      else begin
        t = exp_w[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nk == 8 && i % nk == 4) t = subw(t);
        exp_w[i] = exp_w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++)
      exp_rk[r] = {exp_w[4*r], exp_w[4*r+1], exp_w[4*r+2], exp_w[4*r+3]};
    exp_n = nr + 1;
  endtask

  // ready pattern: low_pct percent of cycles deasserted
  initial forever begin
    @(posedge clk_i);
    #1;
    rk_ready_i = ($urandom_range(99) >= low_pct);
  end

  always @(negedge clk_i) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) hold[d] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (hold[d]) begin
          chk($sformatf("stable_v%0d", d), 128'(v[d]), 128'd1);
          chk($sformatf("stable_rk%0d", d), rk[d], hold_rk[d]);
          chk($sformatf("stable_idx%0d", d), 128'(idx[d]), 128'(hold_idx[d]));
        end
        if (v[d] && rk_ready_i) begin
          if (hs_cnt[d] < exp_n) begin
            chk($sformatf("rk%0d_r%0d", d, hs_cnt[d]), rk[d], exp_rk[hs_cnt[d]]);
            chk($sformatf("idx%0d", d), 128'(idx[d]), 128'(hs_cnt[d]));
            if (timing_chk && d == 0)
              chk("rk_cycle", 128'(cyc), 128'(start_edge + 5 + 4*hs_cnt[d]));
          end else begin
            chk($sformatf("stale_key%0d", d), 128'(idx[d]), 128'hffff);
          end
          hs_cnt[d]++;
          last_hs[d] = cyc;
        end
        if (done[d]) begin
          done_cnt[d]++;
          chk($sformatf("done_lat%0d", d), 128'(cyc - last_hs[d]), 128'd1);
        end
        hold[d]     = v[d] && !rk_ready_i;
        hold_rk[d]  = rk[d];
        hold_idx[d] = idx[d];
      end
    end
  end

  task automatic start_key(input logic [255:0] k, input logic [1:0] kl);
    model(k, kl);
    for (int d = 0; d < 2; d++) begin
      hs_cnt[d] = 0;
      done_cnt[d] = 0;
    end
    @(posedge clk_i);
    #1;
    key_i = k;
    key_len_i = kl;
    start_i = 1'b1;
    start_edge = cyc + 1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  task automatic run_key(input logic [255:0] k, input logic [1:0] kl, input int unsigned lp, input bit tc);
    int n;
    low_pct = lp;
    timing_chk = tc;
    start_key(k, kl);
    // junk start/key while both instances are certainly busy
    for (int j = 0; j < 15; j++) begin
      @(posedge clk_i);
      #1;
      start_i = 1'($urandom_range(1));
      key_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      key_len_i = 2'($urandom_range(3));
    end
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    n = 0;
    while (!(done_cnt[0] >= 1 && done_cnt[1] >= 1) && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    chk("run_timeout", 128'(n >= 3000), 128'd0);
    repeat (3) @(negedge clk_i);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("hs_total%0d", d), 128'(hs_cnt[d]), 128'(exp_n));
      chk($sformatf("done_cnt%0d", d), 128'(done_cnt[d]), 128'd1);
    end
    timing_chk = 1'b0;
  endtask

  initial begin
    int n;
    logic [255:0] rk_rand;
    build_sbox();

    repeat (3) @(negedge clk_i);
    chk("rst_valid", 128'(v), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_rk", rk[0] | rk[1], 128'd0);
    chk("rst_idx", 128'(idx), 128'd0);
    rst_n = 1'b1;

    // model pinned to published vectors
    model(KEY_B, 2'b01);
    chk("m192_w6", 128'(exp_w[6]), 128'hfe0c91f7);
    chk("m192_rk12", exp_rk[12], 128'he98ba06f448c773c8ecc720401002202);
    model(KEY_C, 2'b10);
    chk("m256_w8", 128'(exp_w[8]), 128'h9ba35411);
    chk("m256_rk14", exp_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);
    model(KEY_A, 2'b00);
    chk("m128_rk1", exp_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("m128_rk10", exp_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run_key(KEY_A, 2'b00, 0, 1'b1);
    run_key(KEY_B, 2'b01, 30, 1'b0);
    run_key(KEY_C, 2'b10, 30, 1'b0);
    run_key(KEY_A, 2'b00, 30, 1'b0);

    // abort at round 5, then a fresh 256-bit run
    low_pct = 0;
    start_key(KEY_A, 2'b00);
    n = 0;
    while (!(v[0] && idx[0] == 4'd5) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("clr_reach5", 128'(n >= 200), 128'd0);
    @(posedge clk_i);
    #1;
    clear_i = 1'b1;
    @(posedge clk_i);
    #1;
    clear_i = 1'b0;
    exp_n = 0;
    @(negedge clk_i);
    chk("clr_valid", 128'(v), 128'd0);
    chk("clr_busy", 128'(busy), 128'd0);
    chk("clr_done", 128'(done), 128'd0);
    repeat (3) @(negedge clk_i);
    run_key(KEY_C, 2'b10, 30, 1'b0);

    // async reset in the middle of expansion
    low_pct = 0;
    start_key(KEY_A, 2'b00);
    repeat (10) @(negedge clk_i);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 128'(v), 128'd0);
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_done", 128'(done), 128'd0);
    chk("arst_rk", rk[0] | rk[1], 128'd0);
    chk("arst_idx", 128'(idx), 128'd0);
    exp_n = 0;
    repeat (3) @(negedge clk_i);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_i);
    chk("post_rst_busy", 128'(busy), 128'd0);
    chk("post_rst_valid", 128'(v), 128'd0);

    for (int t = 0; t < 4; t++) begin
      rk_rand = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_key(rk_rand, 2'($urandom_range(3)), 30, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
